// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scanning channel selector and its display decoders.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        PAUSED = 2'd2
    } scan_state_t;

    // Channel index width; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous control inputs, cleared by async reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments let both stages sample pre-edge values; blocking would collapse the chain into one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/scan_channel_mux.sv
// N-channel registered selector: manual select or timed auto-scan with pause.
module scan_channel_mux
    import scan_mux_pkg::*;
#(
    parameter int W     = 3,
    parameter int N     = 5,
    parameter int DWELL = 50_000_000,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic [N*W-1:0]     data_in,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               auto_in,
    input  logic               hold_in,
    output logic [W-1:0]       data_out,
    output logic [SEL_W-1:0]   chan_out,
    output logic               chan_chg
);

    localparam int               CW        = $clog2(DWELL) + 1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(DWELL - 1);
    localparam logic [SEL_W-1:0] CHAN_LAST = SEL_W'(N - 1);

    logic [SEL_W+1:0] sync_bus;
    logic [SEL_W-1:0] sel_s;
    logic             auto_s;
    logic             hold_s;

    sync2 #(.WIDTH(SEL_W + 2)) u_sync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .d     ({sel_in, auto_in, hold_in}),
        .q     (sync_bus)
    );

    assign {sel_s, auto_s, hold_s} = sync_bus;

    scan_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [W-1:0]     data_q, data_d;
    logic             chg_q, chg_d;

    always_comb begin
        state_d = SCAN;
        if (!auto_s) begin
            state_d = MANUAL;
        end else if (hold_s) begin
            state_d = PAUSED;
        end
    end

    // Channel and counter follow the state being entered, so mode changes act on the same edge.
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        chan_d   = chan_q;
        cnt_d    = cnt_q;
        cnt_base = (state_q == MANUAL) ? '0 : cnt_q;
        case (state_d)
            MANUAL: begin
                cnt_d = '0;
                if (int'(sel_s) < N) begin
                    chan_d = sel_s;
                end
            end
            SCAN: begin
                if (cnt_base == CNT_LAST) begin
                    cnt_d  = '0;
                    chan_d = (chan_q == CHAN_LAST) ? '0 : chan_q + 1'b1;
                end else begin
                    cnt_d = cnt_base + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        data_d = '0;
        for (int k = 0; k < N; k++) begin
            if (chan_d == SEL_W'(k)) begin
                data_d = data_in[k*W +: W];
            end
        end
        chg_d = (chan_d != chan_q);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
            chan_q  <= '0;
            data_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            chg_q   <= chg_d;
        end
    end

    assign data_out = data_q;
    assign chan_out = chan_q;
    assign chan_chg = chg_q;

endmodule

// File: tb/tb_scan_channel_mux.sv
// Directed bench: main instance (N=5, DWELL=4) plus DWELL=1 and N=1 corner instances.
module tb_scan_channel_mux;

    logic CLOCK_50;
    logic RESET_N;

    logic [14:0] data_in;
    logic [2:0]  sel_in;
    logic        auto_in, hold_in;
    logic [2:0]  data_out, chan_out;
    logic        chan_chg;

    logic [14:0] d1_data;
    logic [2:0]  d1_sel;
    logic        d1_auto, d1_hold;
    logic [2:0]  d1_dout, d1_chan;
    logic        d1_chg;

    logic [2:0]  n1_data;
    logic [0:0]  n1_sel;
    logic        n1_auto, n1_hold;
    logic [2:0]  n1_dout;
    logic [0:0]  n1_chan;
    logic        n1_chg;

    int checks = 0;
    int errors = 0;

    scan_channel_mux #(.W(3), .N(5), .DWELL(4)) u_main (
        .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .data_in (data_in),
        .sel_in   (sel_in),   .auto_in (auto_in), .hold_in (hold_in),
        .data_out (data_out), .chan_out (chan_out), .chan_chg (chan_chg)
    );

    scan_channel_mux #(.W(3), .N(5), .DWELL(1)) u_d1 (
        .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .data_in (d1_data),
        .sel_in   (d1_sel),   .auto_in (d1_auto), .hold_in (d1_hold),
        .data_out (d1_dout),  .chan_out (d1_chan), .chan_chg (d1_chg)
    );

    scan_channel_mux #(.W(3), .N(1), .DWELL(4)) u_n1 (
        .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .data_in (n1_data),
        .sel_in   (n1_sel),   .auto_in (n1_auto), .hold_in (n1_hold),
        .data_out (n1_dout),  .chan_out (n1_chan), .chan_chg (n1_chg)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        RESET_N = 1'b0;
        data_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        sel_in  = 3'd0; auto_in = 1'b0; hold_in = 1'b0;
        d1_data = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        d1_sel  = 3'd0; d1_auto = 1'b1; d1_hold = 1'b0;
        n1_data = 3'd6; n1_sel = 1'b0; n1_auto = 1'b1; n1_hold = 1'b0;
        #1;
        check("rst_data", 32'(data_out), 0);
        check("rst_chan", 32'(chan_out), 0);
        check("rst_chg",  32'(chan_chg), 0);

        step(2);
        RESET_N = 1'b1;
        step(1);                                    // R+1
        check("idle_data", 32'(data_out), 1);
        check("idle_chan", 32'(chan_out), 0);
        check("d1_start",  32'(d1_chan), 0);
        check("n1_data",   32'(n1_dout), 6);

        // Manual select: visible on the third edge after the change
        sel_in = 3'd3;
        step(2);                                    // R+3
        check("man_lat_chan", 32'(chan_out), 0);
        check("d1_first_adv", 32'(d1_chan), 1);
        check("d1_first_chg", 32'(d1_chg), 1);
        step(1);                                    // R+4
        check("man_chan", 32'(chan_out), 3);
        check("man_data", 32'(data_out), 4);
        check("man_chg",  32'(chan_chg), 1);
        check("d1_adv2",  32'(d1_chan), 2);
        check("n1_chan",  32'(n1_chan), 0);
        step(1);                                    // R+5
        check("man_chg_low", 32'(chan_chg), 0);
        check("d1_adv3",     32'(d1_chan), 3);

        // Out-of-range select is ignored
        sel_in = 3'd7;
        step(3);                                    // R+8
        check("oor_chan", 32'(chan_out), 3);
        check("oor_chg",  32'(chan_chg), 0);
        check("d1_wrap",  32'(d1_chan), 1);
        check("d1_chg",   32'(d1_chg), 1);
        check("n1_chg",   32'(n1_chg), 0);

        // Auto scan from channel 3, wrapping 4 -> 0
        auto_in = 1'b1;
        step(5);                                    // R+13
        check("scan_hold3", 32'(chan_out), 3);
        step(1);                                    // R+14
        check("scan_ch4",     32'(chan_out), 4);
        check("scan_ch4_dat", 32'(data_out), 5);
        check("scan_ch4_chg", 32'(chan_chg), 1);
        step(1);                                    // R+15
        check("scan_chg_low", 32'(chan_chg), 0);
        step(2);                                    // R+17
        check("scan_dwell4", 32'(chan_out), 4);
        step(1);                                    // R+18
        check("wrap_chan", 32'(chan_out), 0);
        check("wrap_data", 32'(data_out), 1);
        check("wrap_chg",  32'(chan_chg), 1);
        step(4);                                    // R+22
        check("scan_ch1",     32'(chan_out), 1);
        check("scan_ch1_dat", 32'(data_out), 2);

        // Pause after two counts on channel 1; resume keeps the count
        hold_in = 1'b1;
        step(2);                                    // R+24
        check("pause_enter", 32'(chan_out), 1);
        step(6);                                    // R+30
        check("pause_frozen", 32'(chan_out), 1);
        check("pause_chg",    32'(chan_chg), 0);
        hold_in = 1'b0;
        step(3);                                    // R+33
        check("resume_wait", 32'(chan_out), 1);
        step(1);                                    // R+34
        check("resume_adv",  32'(chan_out), 2);
        check("resume_data", 32'(data_out), 3);
        check("resume_chg",  32'(chan_chg), 1);

        // Live data change on the selected channel
        data_in[8:6] = 3'd6;
        step(1);                                    // R+35
        check("live_data", 32'(data_out), 6);
        check("live_chg",  32'(chan_chg), 0);
        check("live_chan", 32'(chan_out), 2);

        // Leaving scan jumps straight to the manual select
        auto_in = 1'b0;
        sel_in  = 3'd0;
        step(2);                                    // R+37
        check("exit_wait", 32'(chan_out), 2);
        step(1);                                    // R+38
        check("exit_chan", 32'(chan_out), 0);
        check("exit_data", 32'(data_out), 1);
        check("exit_chg",  32'(chan_chg), 1);
        check("d1_long",   32'(d1_chan), 1);
        check("n1_long",   32'(n1_chan), 0);
        check("n1_nochg",  32'(n1_chg), 0);

        sel_in = 3'd4;
        step(3);                                    // R+41
        check("man4_chan", 32'(chan_out), 4);
        check("man4_data", 32'(data_out), 5);
        check("man4_chg",  32'(chan_chg), 1);

        // Asynchronous reset between edges
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_data", 32'(data_out), 0);
        check("arst_chan", 32'(chan_out), 0);
        check("arst_chg",  32'(chan_chg), 0);
        check("arst_d1",   32'(d1_chan), 0);
        check("arst_n1",   32'(n1_dout), 0);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
